cdb_arbiter: RTL and testbench

Common-data-bus arbiter for the out-of-order core. It collects completed results from the functional units' reservation stations, buffers them in small per-unit FIFOs, and picks one result per cycle with a round-robin policy. It drives the single broadcast channel (valid, value, reservation-station tag) that the register file and the reservation stations snoop to resolve virtual operands.

---
 rtl/cdb_arbiter.sv | 152 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-unit result FIFOs with a round-robin pick onto one broadcast channel.
// Optional same-cycle bypass of an empty FIFO is enabled by defining CDB_BYPASS_EN.
package cdb_arbiter_pkg;
  typedef enum logic [2:0] {
    ALU0, ALU1, ALU2, MUL, DIV, LOAD, STORE, BRANCH
  } e_functional_unit;
endpackage

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_UNITS  = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic [NUM_UNITS-1:0]         result_valid_i,
  input  logic [DATA_WIDTH-1:0]        result_value_i [NUM_UNITS],
  input  e_functional_unit             result_rs_i    [NUM_UNITS],
  output logic [NUM_UNITS-1:0]         result_ready_o,
  output logic                         bcast_valid_o,
  output logic [DATA_WIDTH-1:0]        bcast_value_o,
  output e_functional_unit             bcast_rs_o,
  output logic [$clog2(NUM_UNITS)-1:0] dbg_rr_ptr_o
);

  localparam int PTR_W = $clog2(NUM_UNITS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  // Handshake: unit i transfers on a rising edge where result_valid_i[i] && result_ready_o[i];
  // while valid and not ready the unit holds value/tag stable. Ready depends on registered
  // occupancy only, so a pop in the same cycle gives no credit.

  logic [DATA_WIDTH-1:0] mem_value [NUM_UNITS][FIFO_DEPTH];
  e_functional_unit      mem_rs    [NUM_UNITS][FIFO_DEPTH];
  logic [AW-1:0]         rd_ptr    [NUM_UNITS];
  logic [AW-1:0]         wr_ptr    [NUM_UNITS];
  logic [CW-1:0]         count     [NUM_UNITS];
  logic [PTR_W-1:0]      rr_ptr;

  logic [NUM_UNITS-1:0]  not_empty;
  logic [NUM_UNITS-1:0]  cand;
  logic [NUM_UNITS-1:0]  push;
  logic [NUM_UNITS-1:0]  pop;
  logic                  grant_valid;
  logic                  grant_bypass;
  logic [PTR_W-1:0]      grant_idx;
  logic [PTR_W-1:0]      next_ptr;
  logic [DATA_WIDTH-1:0] grant_value;
  e_functional_unit      grant_rs;

  assign dbg_rr_ptr_o = rr_ptr;

  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      not_empty[i]      = (count[i] != '0);
      result_ready_o[i] = (count[i] != CW'(FIFO_DEPTH));
    end
  end

`ifdef CDB_BYPASS_EN
  // An empty FIFO competes with its live input; non-empty FIFOs compete with their head.
  assign cand = not_empty | result_valid_i;
`else
  assign cand = not_empty;
`endif

  // Round-robin search starting at rr_ptr; first candidate found wins.
  always_comb begin
    int j;
    j           = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_UNITS) j = j - NUM_UNITS;
      if (!grant_valid && cand[j]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(j);
      end
    end
  end

  always_comb begin
    grant_bypass = grant_valid && !not_empty[grant_idx];
    if (grant_bypass) begin
      grant_value = result_value_i[grant_idx];
      grant_rs    = result_rs_i[grant_idx];
    end else begin
      grant_value = mem_value[grant_idx][rd_ptr[grant_idx]];
      grant_rs    = mem_rs[grant_idx][rd_ptr[grant_idx]];
    end
    next_ptr = (grant_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : grant_idx + PTR_W'(1);
  end

  // A bypassed winner is consumed directly and never enters its FIFO.
  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      pop[i]  = grant_valid && (grant_idx == PTR_W'(i)) && not_empty[i];
      push[i] = result_valid_i[i] && result_ready_o[i] &&
                !(grant_bypass && (grant_idx == PTR_W'(i)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr        <= '0;
      bcast_valid_o <= 1'b0;
      bcast_value_o <= '0;
      bcast_rs_o    <= e_functional_unit'('0);
    end else if (flush_i) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      bcast_valid_o <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        if (push[i] && !pop[i])      count[i] <= count[i] + CW'(1);
        else if (pop[i] && !push[i]) count[i] <= count[i] - CW'(1);
      end
      bcast_valid_o <= grant_valid;
      if (grant_valid) begin
        bcast_value_o <= grant_value;
        bcast_rs_o    <= grant_rs;
        rr_ptr        <= next_ptr;
      end
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (push[i] && !flush_i) begin
        mem_value[i][wr_ptr[i]] <= result_value_i[i];
        mem_rs[i][wr_ptr[i]]    <= result_rs_i[i];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: random and directed traffic, queue-based reference model, scoreboard monitor.
// Follows CDB_BYPASS_EN the same way as the design.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int DATA_WIDTH = 64;
  localparam int NUM_UNITS  = 3;
  localparam int FIFO_DEPTH = 2;
  localparam int PTR_W      = $clog2(NUM_UNITS);
  localparam int ENT_W      = 3 + DATA_WIDTH;
  localparam int EXP_W      = 32 + ENT_W;

  logic                  clk;
  logic                  rst_n;
  logic                  flush;
  logic [NUM_UNITS-1:0]  valid;
  logic [DATA_WIDTH-1:0] value [NUM_UNITS];
  e_functional_unit      rs    [NUM_UNITS];
  logic [NUM_UNITS-1:0]  ready;
  logic                  bcast_valid;
  logic [DATA_WIDTH-1:0] bcast_value;
  e_functional_unit      bcast_rs;
  logic [PTR_W-1:0]      dbg_ptr;

  cdb_arbiter #(
    .DATA_WIDTH(DATA_WIDTH), .NUM_UNITS(NUM_UNITS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .result_valid_i(valid), .result_value_i(value), .result_rs_i(rs),
    .result_ready_o(ready),
    .bcast_valid_o(bcast_valid), .bcast_value_o(bcast_value), .bcast_rs_o(bcast_rs),
    .dbg_rr_ptr_o(dbg_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // reference model state
  logic [ENT_W-1:0] mq [NUM_UNITS][$];
  logic [EXP_W-1:0] exp_q[$];
  logic [ENT_W-1:0] last_ent;
  logic [NUM_UNITS-1:0] acc;
  int ptr;
  int cyc;

  initial begin
    ptr = 0; cyc = 0; acc = '0; last_ent = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < NUM_UNITS; i++) mq[i].delete();
        exp_q.delete();
        ptr = 0; acc = '0; last_ent = '0;
      end else begin
        int win;
        logic byp;
        logic [ENT_W-1:0] e;
        cyc++;
        for (int i = 0; i < NUM_UNITS; i++)
          acc[i] = valid[i] && (mq[i].size() < FIFO_DEPTH);
        if (flush) begin
          for (int i = 0; i < NUM_UNITS; i++) mq[i].delete();
        end else begin
          win = -1; byp = 1'b0; e = '0;
          for (int k = 0; k < NUM_UNITS; k++) begin
            int u;
            u = (ptr + k) % NUM_UNITS;
            if (win < 0) begin
              if (mq[u].size() > 0) begin
                win = u;
                e = mq[u].pop_front();
              end
`ifdef CDB_BYPASS_EN
              else if (valid[u]) begin
                win = u;
                e = {rs[u], value[u]};
                byp = 1'b1;
              end
`endif
            end
          end
          if (win >= 0) begin
            exp_q.push_back({32'(cyc), e});
            last_ent = e;
            ptr = (win + 1) % NUM_UNITS;
          end
          for (int i = 0; i < NUM_UNITS; i++)
            if (acc[i] && !(byp && win == i)) mq[i].push_back({rs[i], value[i]});
        end
      end
    end
  end

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < NUM_UNITS; i++)
          chk($sformatf("ready[%0d]", i), 128'(ready[i]), 128'(mq[i].size() < FIFO_DEPTH));
        chk("rr_ptr", 128'(dbg_ptr), 128'(ptr));
        if (bcast_valid) begin
          if (exp_q.size() == 0) begin
            chk("bcast_unexpected", 128'({bcast_rs, bcast_value}), 128'(0));
            if ({bcast_rs, bcast_value} == '0) chk("bcast_unexpected_valid", 128'(1), 128'(0));
          end else begin
            logic [EXP_W-1:0] x;
            x = exp_q.pop_front();
            chk("bcast_data", 128'({32'(cyc), bcast_rs, bcast_value}), 128'(x));
          end
        end else begin
          chk("bcast_hold", 128'({bcast_rs, bcast_value}), 128'(last_ent));
          if (exp_q.size() > 0 && int'(exp_q[0][EXP_W-1:ENT_W]) <= cyc) begin
            logic [EXP_W-1:0] x;
            x = exp_q.pop_front();
            chk("bcast_missing", 128'(0), 128'(x));
          end
        end
      end
    end
  end

  // driver
  int p_pct [NUM_UNITS];
  int flush_pm;

  task automatic set_p(input int p);
    for (int i = 0; i < NUM_UNITS; i++) p_pct[i] = p;
  endtask

  task automatic drive_cycle();
    @(negedge clk);
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (!(valid[i] && !acc[i])) begin
        valid[i] = ($urandom_range(0, 99) < p_pct[i]);
        value[i] = {$urandom, $urandom};
        rs[i]    = e_functional_unit'(3'($urandom_range(0, 7)));
      end
    end
    flush = ($urandom_range(0, 999) < flush_pm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_n = 1'b0; flush = 1'b0; valid = '0; flush_pm = 0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      value[i] = '0; rs[i] = ALU0; p_pct[i] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_bcast_valid", 128'(bcast_valid), 128'(0));
    chk("rst_bcast_value", 128'(bcast_value), 128'(0));
    chk("rst_bcast_rs", 128'(bcast_rs), 128'(0));
    chk("rst_ready", 128'(ready), 128'({NUM_UNITS{1'b1}}));
    chk("rst_ptr", 128'(dbg_ptr), 128'(0));
    #1 rst_n = 1'b1;

    // single result on unit 1
    @(negedge clk);
    valid[1] = 1'b1; value[1] = 64'hDEAD; rs[1] = ALU1;
    @(negedge clk);
    valid[1] = 1'b0;
    repeat (5) drive_cycle();

    // all units continuously busy: round-robin with wrap
    set_p(100);
    repeat (12) drive_cycle();

    // unit 2 contends against always-busy units 0 and 1
    p_pct[2] = 60;
    repeat (20) drive_cycle();

    // fill, then flush with a same-cycle push on unit 0
    set_p(100);
    repeat (3) drive_cycle();
    set_p(0);
    @(negedge clk);
    flush = 1'b1; valid = 3'b001; value[0] = 64'hF1F1; rs[0] = MUL;
    repeat (6) drive_cycle();

    // idle
    repeat (10) drive_cycle();

    // randomized traffic with occasional flushes
    flush_pm = 15;
    for (int ph = 0; ph < 15; ph++) begin
      for (int i = 0; i < NUM_UNITS; i++) p_pct[i] = $urandom_range(0, 100);
      repeat (100) drive_cycle();
    end
    flush_pm = 0;

    // asynchronous reset while a broadcast is on the bus
    set_p(100);
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      drive_cycle();
      if (bcast_valid) seen = 1'b1;
    end
    chk("rst_mid_bcast_seen", 128'(seen), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 128'(bcast_valid), 128'(0));
    chk("async_rst_ptr", 128'(dbg_ptr), 128'(0));
    chk("async_rst_value", 128'(bcast_value), 128'(0));
    chk("async_rst_ready", 128'(ready), 128'({NUM_UNITS{1'b1}}));
    set_p(0); valid = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // short burst after reset, then drain
    set_p(70);
    repeat (50) drive_cycle();
    set_p(0);
    repeat (30) drive_cycle();
    chk("drain_exp_q_empty", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
